// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte sources.
// One byte per grant: launch pulse, wait for done (or timeout), optional gap, re-arbitrate.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 0,
    parameter int TIMEOUT_CLKS = 20000
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic [NUM_REQ-1:0]     i_Req_Valid,
    input  logic [8*NUM_REQ-1:0]   i_Req_Data,
    output logic [NUM_REQ-1:0]     o_Req_Ready,
    output logic                   o_TX_DV,
    output logic [7:0]             o_TX_Byte,
    input  logic                   i_TX_Active,
    input  logic                   i_TX_Done,
    output logic [2:0]             o_Grant_Id,
    output logic                   o_Busy,
    output logic                   o_Err,
    output logic [1:0]             o_Dbg_State
);

    localparam int CNT_MAX = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    // Handshake: a requester holds valid/data until it sees its one-cycle ready
    // pulse, which coincides with o_TX_DV; dropping valid earlier withdraws it.

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [7:0]           byte_q, byte_d;
    logic [2:0]           grant_q, grant_d;
    logic                 dv_q, dv_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    state_t               after_byte;

    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offs);
        int s;
        s = (int'(base) + offs) % NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Search starts just after the last winner and ends on it.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!win_found && i_Req_Valid[rr_index(last_q, i)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(last_q, i);
            end
        end
    end

    assign after_byte = (GAP_CLKS == 0) ? IDLE : GAP;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        byte_d  = byte_q;
        grant_d = grant_q;
        err_d   = err_q;
        dv_d    = 1'b0;
        ready_d = '0;
        case (state_q)
            IDLE: begin
                if (win_found && !i_TX_Active) begin
                    byte_d  = i_Req_Data[8*int'(win_idx) +: 8];
                    grant_d = 3'(win_idx);
                    last_d  = win_idx;
                    cnt_d   = '0;
                    dv_d    = 1'b1;
                    ready_d = NUM_REQ'(1) << win_idx;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                // A done seen here belongs to an earlier frame.
                cnt_d   = cnt_q + 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_TX_Done) begin
                    cnt_d   = '0;
                    state_d = after_byte;
                end else if (cnt_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = after_byte;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CLKS - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            byte_q  <= '0;
            grant_q <= '0;
            dv_q    <= 1'b0;
            ready_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            grant_q <= grant_d;
            dv_q    <= dv_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign o_Req_Ready = ready_q;
    assign o_TX_DV     = dv_q;
    assign o_TX_Byte   = byte_q;
    assign o_Grant_Id  = grant_q;
    assign o_Busy      = busy_q;
    assign o_Err       = err_q;
    assign o_Dbg_State = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized round-robin run
// checked against a transaction-level arbitration model.
module tb_uart_tx_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] req_data;
    logic        active;
    logic        done;
    logic [7:0]  req_byte [4];

    logic [3:0] ready_a, ready_b;
    logic       dv_a, dv_b;
    logic [7:0] byte_a, byte_b;
    logic [2:0] grant_a, grant_b;
    logic       busy_a, busy_b;
    logic       err_a, err_b;
    logic [1:0] st_a, st_b;

    int n_checks = 0;
    int n_fail = 0;
    logic [10:0] exp_q[$];

    assign req_data = {req_byte[3], req_byte[2], req_byte[1], req_byte[0]};

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(0), .TIMEOUT_CLKS(100)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_Req_Valid(valid), .i_Req_Data(req_data),
        .o_Req_Ready(ready_a), .o_TX_DV(dv_a), .o_TX_Byte(byte_a),
        .i_TX_Active(active), .i_TX_Done(done), .o_Grant_Id(grant_a),
        .o_Busy(busy_a), .o_Err(err_a), .o_Dbg_State(st_a));

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(5), .TIMEOUT_CLKS(100)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_Req_Valid(valid), .i_Req_Data(req_data),
        .o_Req_Ready(ready_b), .o_TX_DV(dv_b), .o_TX_Byte(byte_b),
        .i_TX_Active(active), .i_TX_Done(done), .o_Grant_Id(grant_b),
        .o_Busy(busy_b), .o_Err(err_b), .o_Dbg_State(st_b));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; valid = '0; active = 1'b0; done = 1'b0;
        for (int k = 0; k < 4; k++) req_byte[k] = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_dv_a(input int max, output int n);
        n = 0;
        while (dv_a !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_done;
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    // Reference arbitration rule: first pending index after the last winner.
    function automatic int model_pick(input logic [3:0] v, input int last);
        for (int i = 1; i <= 4; i++)
            if (v[(last + i) % 4]) return (last + i) % 4;
        return -1;
    endfunction

    task automatic test_reset;
        rst = 1'b1; valid = 4'hF; active = 1'b0; done = 1'b0;
        tick();
        n_checks++;
        if ({dv_a, ready_a, byte_a, grant_a, busy_a, err_a, st_a} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_a: got dv=%b rdy=%b byte=%h gnt=%0d busy=%b err=%b st=%0d, want all 0",
                     dv_a, ready_a, byte_a, grant_a, busy_a, err_a, st_a);
        end
        n_checks++;
        if ({dv_b, ready_b, busy_b, err_b} !== 7'h0) begin
            n_fail++;
            $display("FAIL reset_b: got dv=%b rdy=%b busy=%b err=%b, want 0", dv_b, ready_b, busy_b, err_b);
        end
        do_reset();
    endtask

    task automatic test_single;
        int n;
        do_reset();
        req_byte[2] = 8'hA5; valid = 4'b0100;
        tick();
        n_checks++;
        if ({dv_a, byte_a, ready_a, grant_a} !== {1'b1, 8'hA5, 4'b0100, 3'd2}) begin
            n_fail++;
            $display("FAIL single_launch: got dv=%b byte=%h rdy=%b gnt=%0d, want 1 a5 0100 2",
                     dv_a, byte_a, ready_a, grant_a);
        end
        valid = '0;
        tick();
        n_checks++;
        if ({dv_a, ready_a, busy_a} !== {1'b0, 4'b0000, 1'b1}) begin
            n_fail++;
            $display("FAIL single_pulse_width: got dv=%b rdy=%b busy=%b, want 0 0000 1", dv_a, ready_a, busy_a);
        end
        repeat (49) tick();
        pulse_done();
        n_checks++;
        if ({busy_a, byte_a, err_a} !== {1'b0, 8'hA5, 1'b0}) begin
            n_fail++;
            $display("FAIL single_done: got busy=%b byte=%h err=%b, want 0 a5 0", busy_a, byte_a, err_a);
        end
        n = 0;
    endtask

    task automatic test_simultaneous;
        int n;
        int readies;
        do_reset();
        req_byte[1] = 8'h11; req_byte[3] = 8'h33; valid = 4'b1010;
        readies = 0;
        tick();
        if (|ready_a) readies++;
        n_checks++;
        if ({grant_a, byte_a, ready_a} !== {3'd1, 8'h11, 4'b0010}) begin
            n_fail++;
            $display("FAIL simul_first: got gnt=%0d byte=%h rdy=%b, want 1 11 0010", grant_a, byte_a, ready_a);
        end
        valid[1] = 1'b0;
        repeat (6) begin tick(); if (|ready_a) readies++; end
        pulse_done();
        wait_dv_a(10, n);
        if (|ready_a) readies++;
        n_checks++;
        if ({dv_a, grant_a, byte_a, ready_a} !== {1'b1, 3'd3, 8'h33, 4'b1000}) begin
            n_fail++;
            $display("FAIL simul_second: got dv=%b gnt=%0d byte=%h rdy=%b, want 1 3 33 1000",
                     dv_a, grant_a, byte_a, ready_a);
        end
        valid[3] = 1'b0;
        repeat (4) begin tick(); if (|ready_a) readies++; end
        pulse_done();
        repeat (4) begin tick(); if (|ready_a) readies++; end
        n_checks++;
        if (readies !== 2) begin
            n_fail++;
            $display("FAIL simul_ready_count: got %0d ready pulses, want 2", readies);
        end
    endtask

    task automatic test_fairness;
        int n, w, last;
        logic [10:0] exp;
        do_reset();
        for (int k = 0; k < 4; k++) req_byte[k] = 8'(k * 16);
        valid = 4'hF;
        last = 3;
        for (int b = 0; b < 8; b++) begin
            w = model_pick(valid, last);
            exp_q.push_back({3'(w), req_byte[w]});
            wait_dv_a(10, n);
            exp = exp_q.pop_front();
            n_checks++;
            if (dv_a !== 1'b1 || n !== 1 || {grant_a, byte_a} !== exp || grant_a !== 3'(b % 4)) begin
                n_fail++;
                $display("FAIL fair_grant%0d: got dv=%b lat=%0d gnt=%0d byte=%h, want 1 1 %0d %h",
                         b, dv_a, n, grant_a, byte_a, exp[10:8], exp[7:0]);
            end
            last = w;
            req_byte[w] = req_byte[w] + 8'd1;
            repeat (10) tick();
            pulse_done();
        end
        valid = '0;
        tick();
    endtask

    task automatic test_launch_done;
        int n;
        do_reset();
        req_byte[1] = 8'h77; valid = 4'b0010;
        wait_dv_a(5, n);
        valid = 4'b1000;
        done = 1'b1;
        tick();
        done = 1'b0;
        valid = 4'b0000;
        repeat (4) tick();
        n_checks++;
        if ({busy_a, st_a, dv_a} !== {1'b1, 2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL launch_done_ignored: got busy=%b st=%0d dv=%b, want 1 2 0", busy_a, st_a, dv_a);
        end
        req_byte[0] = 8'h0E; valid = 4'b0001;
        pulse_done();
        wait_dv_a(5, n);
        n_checks++;
        if ({dv_a, grant_a, byte_a} !== {1'b1, 3'd0, 8'h0E}) begin
            n_fail++;
            $display("FAIL withdraw_then_grant: got dv=%b gnt=%0d byte=%h, want 1 0 0e", dv_a, grant_a, byte_a);
        end
        valid = '0;
        tick();
        pulse_done();
    endtask

    task automatic test_gap;
        int n;
        do_reset();
        req_byte[0] = 8'hA0; req_byte[1] = 8'hB1; valid = 4'b0011;
        n = 0;
        while (dv_b !== 1'b1 && n < 5) begin tick(); n++; end
        valid[0] = 1'b0;
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n = 1;
        n_checks++;
        if ({busy_b, st_b} !== {1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL gap_entered: got busy=%b st=%0d, want 1 3", busy_b, st_b);
        end
        while (dv_b !== 1'b1 && n < 50) begin tick(); n++; end
        n_checks++;
        if (dv_b !== 1'b1 || n !== 7 || grant_b !== 3'd1 || byte_b !== 8'hB1) begin
            n_fail++;
            $display("FAIL gap_latency: got dv=%b cycles=%0d gnt=%0d byte=%h, want 1 7 1 b1",
                     dv_b, n, grant_b, byte_b);
        end
        valid = '0;
        tick();
        pulse_done();
    endtask

    task automatic test_timeout;
        int n;
        do_reset();
        req_byte[0] = 8'h5A; req_byte[1] = 8'hC3; valid = 4'b0011;
        wait_dv_a(5, n);
        valid[0] = 1'b0;
        n = 0;
        while (err_a !== 1'b1 && n < 200) begin tick(); n++; end
        n_checks++;
        if (err_a !== 1'b1 || n !== 100 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%b after %0d cycles busy=%b, want 1 100 0", err_a, n, busy_a);
        end
        tick();
        n_checks++;
        if ({dv_a, grant_a, byte_a} !== {1'b1, 3'd1, 8'hC3}) begin
            n_fail++;
            $display("FAIL timeout_next: got dv=%b gnt=%0d byte=%h, want 1 1 c3", dv_a, grant_a, byte_a);
        end
        valid = '0;
        repeat (5) tick();
        pulse_done();
        n_checks++;
        if (err_a !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b, want 1", err_a);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        req_byte[2] = 8'h42; valid = 4'b0100;
        wait_dv_a(5, n);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({dv_a, ready_a, byte_a, grant_a, busy_a, err_a, st_a} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got dv=%b rdy=%b byte=%h gnt=%0d busy=%b err=%b st=%0d, want all 0",
                     dv_a, ready_a, byte_a, grant_a, busy_a, err_a, st_a);
        end
        rst = 1'b0;
        req_byte[0] = 8'hD0; req_byte[3] = 8'hD3; valid = 4'b1001;
        tick();
        n_checks++;
        if ({dv_a, grant_a, byte_a, ready_a, err_a} !== {1'b1, 3'd0, 8'hD0, 4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_regrant: got dv=%b gnt=%0d byte=%h rdy=%b err=%b, want 1 0 d0 0001 0",
                     dv_a, grant_a, byte_a, ready_a, err_a);
        end
        valid = '0;
        tick();
        pulse_done();
    endtask

    task automatic test_random;
        int n, w, last, blk, dly;
        logic [10:0] exp;
        do_reset();
        last = 3;
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < 4; k++) begin
                if (valid[k] && $urandom_range(0, 3) == 0) valid[k] = 1'b0;
                else if (!valid[k] && $urandom_range(0, 1) == 1) begin
                    valid[k] = 1'b1;
                    req_byte[k] = 8'($urandom);
                end
            end
            if (valid == 4'b0) begin
                w = $urandom_range(0, 3);
                valid[w] = 1'b1;
                req_byte[w] = 8'($urandom);
            end
            blk = $urandom_range(0, 3);
            active = (blk != 0);
            for (int c = 0; c < blk; c++) begin
                tick();
                n_checks++;
                if (dv_a !== 1'b0 || ready_a !== 4'b0 || busy_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_blocked%0d: got dv=%b rdy=%b busy=%b, want 0 0000 0", it, dv_a, ready_a, busy_a);
                end
            end
            active = 1'b0;
            w = model_pick(valid, last);
            exp_q.push_back({3'(w), req_byte[w]});
            tick();
            exp = exp_q.pop_front();
            n_checks++;
            if (dv_a !== 1'b1 || {grant_a, byte_a} !== exp || ready_a !== (4'b0001 << w)) begin
                n_fail++;
                $display("FAIL rand_grant%0d: got dv=%b gnt=%0d byte=%h rdy=%b, want 1 %0d %h %b",
                         it, dv_a, grant_a, byte_a, ready_a, exp[10:8], exp[7:0], 4'b0001 << w);
            end
            last = w;
            if ($urandom_range(0, 1) == 1) valid[w] = 1'b0;
            else req_byte[w] = 8'($urandom);
            dly = $urandom_range(1, 30);
            repeat (dly) tick();
            pulse_done();
        end
        valid = '0;
        tick();
    endtask

    initial begin
        rst = 1'b1; valid = '0; active = 1'b0; done = 1'b0;
        for (int k = 0; k < 4; k++) req_byte[k] = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_launch_done();
        test_gap();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter between NUM_REQ byte-producing requesters, e.g. the RX echo path, the 7-segment status reporter and debug sources. It accepts one byte at a time from a requester and launches it on the transmitter with a one-cycle data-valid pulse. It then waits for the transmitter's done pulse, inserts an optional inter-byte gap, and re-arbitrates. A watchdog recovers the arbiter if the transmitter never reports done.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
GAP_CLKS, 0, idle i_Clk cycles inserted after each byte before re-arbitration; 0 means no gap state.
TIMEOUT_CLKS, 20000, maximum cycles to wait for i_TX_Done; must exceed 10*CLKS_PER_BIT of the transmitter (8680 at 100 MHz/115200).

Ports:
i_Clk  input  1  system clock; single clock domain.
i_Rst  input  1  synchronous reset, active-high.
i_Req_Valid  input  NUM_REQ  per-requester byte-pending flag.
i_Req_Data  input  8*NUM_REQ  requester k's byte at bits [8k+7:8k].
o_Req_Ready  output  NUM_REQ  one-cycle pulse: requester k's byte was accepted.
o_TX_DV  output  1  one-cycle launch pulse to the transmitter.
o_TX_Byte  output  8  byte to transmit; stable from the launch until the next grant.
i_TX_Active  input  1  transmitter busy; used only as a launch blocker.
i_TX_Done  input  1  transmitter one-cycle completion pulse.
o_Grant_Id  output  3  index of the current or most recent grant.
o_Busy  output  1  high in every state except IDLE.
o_Err  output  1  sticky flag: a timeout has occurred.

Behaviour:
- Reset values at the first i_Clk edge with i_Rst=1: state IDLE, o_Req_Ready=0, o_TX_DV=0, o_TX_Byte=0, o_Grant_Id=0, o_Busy=0, o_Err=0, round-robin pointer r_Last=NUM_REQ-1 (so requester 0 has top priority first), counters=0.
- Reset mid-operation: abandon the transfer. No Ready or DV pulse is emitted after reset is sampled. A transmitter frame already in flight is not the arbiter's concern.
- All outputs are registered.
- IDLE:
  - Wait until any i_Req_Valid is high and i_TX_Active=0.
  - Winner = first valid index searching r_Last+1, r_Last+2, … wrapping modulo NUM_REQ, ending at r_Last.
  - On that edge: latch i_Req_Data of the winner into o_TX_Byte; set o_Grant_Id and r_Last to the winner; go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - o_TX_DV=1 and o_Req_Ready[winner]=1 in the same cycle; both are 0 in every other cycle.
  - Go to WAIT_DONE.
  - If i_TX_Done is sampled in this cycle it is ignored, because it belongs to a previous frame.
- WAIT_DONE:
  - Count cycles.
  - On i_TX_Done=1: go to GAP, or directly to IDLE when GAP_CLKS=0.
  - If the count reaches TIMEOUT_CLKS-1 without i_TX_Done: set o_Err=1 and go to GAP or IDLE as above.
- GAP: stay GAP_CLKS cycles, then go to IDLE. Valid inputs are ignored here.
- Latency: valid sampled in IDLE at edge N (transmitter idle) → o_TX_DV and o_Req_Ready high in cycle N+1.
- Requester rules:
  - Hold valid and data stable until it sees Ready.
  - Ready is sampled together with the byte.
  - A requester may keep valid high to queue its next byte. That byte is eligible only at the next IDLE, after other pending requesters per round-robin.
- Dropping valid before Ready withdraws the request with no side effect.
- Fairness: with all NUM_REQ valid continuously, grants cycle 0,1,…,NUM_REQ-1,0,…; no requester waits more than NUM_REQ-1 other bytes.
- i_TX_Active=1 in IDLE blocks arbitration; the pointer is unchanged.
- o_Err clears only on i_Rst.
- Counters are sized by $clog2 of their parameter + 1; there is no wrap-around in any state.

Test Plan:
- Single requester: after reset, req 2 valid with 8'hA5, TX idle → cycle+1: o_TX_DV=1, o_TX_Byte=A5, o_Req_Ready=4'b0100, o_Grant_Id=2; Done pulse 50 cycles later → o_Busy falls the next cycle.
- Simultaneous: reqs 1 and 3 valid (8'h11, 8'h33) right after reset → grant 1 first, then grant 3 after Done; bytes 11 then 33; two Ready pulses total.
- Fairness: all 4 valid continuously with Done 10 cycles after each DV → grant sequence 0,1,2,3,0,1,2,3 over 8 bytes.
- Gap: GAP_CLKS=5, two queued requests → next o_TX_DV occurs exactly 1+5+1 cycles after the Done pulse.
- Timeout: TIMEOUT_CLKS=100, Done never pulsed → o_Err=1 exactly 100 cycles after DV, arbiter returns to IDLE and the next pending byte launches.
- Reset mid-transfer: i_Rst in WAIT_DONE → all outputs at reset values the next cycle; later request from req 0 is granted normally and o_Err stays 0.
